// File: rtl/blackice_mx_pll_seq_pkg.sv
// Shared types and helpers for the BlackIce MX PLL bring-up sequencer.
package blackice_mx_pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        SDRAM_REL,
        RUN,
        FAULT
    } seq_state_e;

    typedef struct packed {
        logic pll_resetb;
        logic sdram_reset;
        logic system_reset;
        logic ready;
        logic fault;
    } seq_out_t;

    // Bits needed to hold the largest of the four cycle-count parameters.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

    // Output pattern presented while the sequencer sits in a given state.
    function automatic seq_out_t state_outputs(input seq_state_e s);
        seq_out_t o;
        o = '{pll_resetb: 1'b1, sdram_reset: 1'b1, system_reset: 1'b1,
              ready: 1'b0, fault: 1'b0};
        case (s)
            PLL_RST:   o.pll_resetb = 1'b0;
            SDRAM_REL: o.sdram_reset = 1'b0;
            RUN: begin
                o.sdram_reset  = 1'b0;
                o.system_reset = 1'b0;
                o.ready        = 1'b1;
            end
            FAULT: begin
                o.pll_resetb = 1'b0;
                o.fault      = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/blackice_mx_sync2.sv
// Two-flop synchronizer with synchronous active-high clear.
module blackice_mx_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/blackice_mx_pll_sequencer.sv
// PLL40 bring-up sequencer: pulses RESETB, waits for a stable lock with retry,
// then releases the SDRAM and system resets in order.
module blackice_mx_pll_sequencer
    import blackice_mx_pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RESET_CYCLES   = 32,
    parameter int unsigned LOCK_TIMEOUT       = 65535,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned SDRAM_TO_SYS_GAP   = 16,
    parameter int unsigned MAX_RETRIES        = 7,
    localparam int unsigned RETRY_W           = $clog2(MAX_RETRIES + 1)
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               soft_restart,
    input  logic               fault_clear,
    output logic               pll_resetb,
    output logic               sdram_reset,
    output logic               system_reset,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int unsigned CNT_W = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT,
                                              LOCK_STABLE_CYCLES, SDRAM_TO_SYS_GAP);
    localparam int unsigned PLL_LAST    = PLL_RESET_CYCLES - 1;
    localparam int unsigned TIMEOUT_LAST = LOCK_TIMEOUT - 1;
    localparam int unsigned STABLE_LAST = LOCK_STABLE_CYCLES - 1;
    localparam int unsigned GAP_LAST    = (SDRAM_TO_SYS_GAP == 0) ? 0 : SDRAM_TO_SYS_GAP - 1;
    // Saturation point: MAX_RETRIES+1 unless that does not fit the port width.
    localparam int unsigned RETRY_MAX_ENC = (2 ** RETRY_W) - 1;
    localparam int unsigned RETRY_SAT = (MAX_RETRIES + 1 > RETRY_MAX_ENC) ?
                                        RETRY_MAX_ENC : MAX_RETRIES + 1;

    seq_state_e       state;
    seq_out_t         outs_q;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;
    logic             sr_q;
    logic             sr_rise_c;

    blackice_mx_sync2 u_lock_sync (
        .clk (clock_in),
        .rst (reset),
        .d   (pll_locked),
        .q   (lock_s)
    );

    assign sr_rise_c = soft_restart & ~sr_q;

    // Sequencer FSM; outputs are loaded together with each state change.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state       <= PLL_RST;
            outs_q      <= state_outputs(PLL_RST);
            cnt         <= '0;
            retry_count <= '0;
            sr_q        <= 1'b0;
        end else begin
            sr_q <= soft_restart;
            if (sr_rise_c && (state != FAULT)) begin
                state  <= PLL_RST;
                outs_q <= state_outputs(PLL_RST);
                cnt    <= '0;
            end else begin
                case (state)
                    PLL_RST: begin
                        if (cnt == CNT_W'(PLL_LAST)) begin
                            state  <= WAIT_LOCK;
                            outs_q <= state_outputs(WAIT_LOCK);
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state  <= STABLE;
                            outs_q <= state_outputs(STABLE);
                            cnt    <= '0;
                        end else if (cnt == CNT_W'(TIMEOUT_LAST)) begin
                            cnt <= '0;
                            if (retry_count != RETRY_W'(RETRY_SAT)) begin
                                retry_count <= retry_count + RETRY_W'(1);
                            end
                            // Incremented count exceeding MAX_RETRIES gives up.
                            if (retry_count >= RETRY_W'(MAX_RETRIES)) begin
                                state  <= FAULT;
                                outs_q <= state_outputs(FAULT);
                            end else begin
                                state  <= PLL_RST;
                                outs_q <= state_outputs(PLL_RST);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    STABLE: begin
                        if (!lock_s) begin
                            cnt <= '0;
                        end else if (cnt == CNT_W'(STABLE_LAST)) begin
                            state  <= SDRAM_REL;
                            outs_q <= state_outputs(SDRAM_REL);
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    SDRAM_REL: begin
                        if (!lock_s) begin
                            state  <= PLL_RST;
                            outs_q <= state_outputs(PLL_RST);
                            cnt    <= '0;
                        end else if (cnt == CNT_W'(GAP_LAST)) begin
                            state  <= RUN;
                            outs_q <= state_outputs(RUN);
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RUN: begin
                        cnt <= '0;
                        if (!lock_s) begin
                            state  <= PLL_RST;
                            outs_q <= state_outputs(PLL_RST);
                        end
                    end
                    FAULT: begin
                        cnt <= '0;
                        if (fault_clear) begin
                            state       <= PLL_RST;
                            outs_q      <= state_outputs(PLL_RST);
                            retry_count <= '0;
                        end
                    end
                    default: begin
                        state  <= PLL_RST;
                        outs_q <= state_outputs(PLL_RST);
                        cnt    <= '0;
                    end
                endcase
            end
        end
    end

    assign pll_resetb   = outs_q.pll_resetb;
    assign sdram_reset  = outs_q.sdram_reset;
    assign system_reset = outs_q.system_reset;
    assign ready        = outs_q.ready;
    assign fault        = outs_q.fault;

endmodule

// File: tb/tb_blackice_mx_pll_sequencer.sv
// Scoreboard bench: stimulus queues the expected output transitions with their
// cycle stamps; a monitor compares every observed output change against them.
module tb_blackice_mx_pll_sequencer;

    localparam int unsigned PRC  = 4;
    localparam int unsigned LTO  = 20;
    localparam int unsigned LSC  = 8;
    localparam int unsigned GAP  = 3;
    localparam int unsigned MR   = 2;
    localparam int unsigned RW   = $clog2(MR + 1);
    // pll_locked driven after edge k is first acted on by the FSM at edge k+3
    localparam int unsigned SYNC_DET = 3;

    logic          clock_in = 1'b0;
    logic          reset = 1'b1;
    logic          pll_locked = 1'b0;
    logic          soft_restart = 1'b0;
    logic          fault_clear = 1'b0;
    logic          pll_resetb, sdram_reset, system_reset, ready, fault;
    logic [RW-1:0] retry_count;
    logic [6:0]    cur, prev;

    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b0;

    typedef struct {
        int unsigned at;
        logic [6:0]  outs;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    blackice_mx_pll_sequencer #(
        .PLL_RESET_CYCLES   (PRC),
        .LOCK_TIMEOUT       (LTO),
        .LOCK_STABLE_CYCLES (LSC),
        .SDRAM_TO_SYS_GAP   (GAP),
        .MAX_RETRIES        (MR)
    ) dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .soft_restart (soft_restart),
        .fault_clear  (fault_clear),
        .pll_resetb   (pll_resetb),
        .sdram_reset  (sdram_reset),
        .system_reset (system_reset),
        .ready        (ready),
        .fault        (fault),
        .retry_count  (retry_count)
    );

    always #20 clock_in = ~clock_in;
    always @(posedge clock_in) cyc <= cyc + 1;

    assign cur = {pll_resetb, sdram_reset, system_reset, ready, fault, retry_count};

    function automatic logic [6:0] ov(input bit pb, input bit sd, input bit sy,
                                      input bit rd, input bit ft, input logic [1:0] rc);
        return {pb, sd, sy, rd, ft, rc};
    endfunction

    task automatic expect_at(input int unsigned at, input logic [6:0] o, input string nm);
        exp_t e;
        e.at = at;
        e.outs = o;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    // Monitor: every output change must match the next queued expectation.
    always @(negedge clock_in) begin
        exp_t e;
        if (mon_en) begin
            vectors++;
            if (sdram_reset === 1'b1 && system_reset === 1'b0) begin
                miscompares++;
                $display("FAIL reset_order cyc=%0d sdram_reset=1 system_reset=0 (need system_reset=1)", cyc);
            end
            if (cur !== prev) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change cyc=%0d got=%b prev=%b", cyc, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at != cyc || e.outs !== cur) begin
                        miscompares++;
                        $display("FAIL %s got=%b@%0d expected=%b@%0d", e.name, cur, cyc, e.outs, e.at);
                    end
                end
                prev = cur;
            end else if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL %s no change seen, outputs=%b@%0d expected=%b@%0d",
                         e.name, cur, cyc, e.outs, e.at);
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog cyc=%0d queue=%0d", cyc, exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, w, r, l, s, q, e, c, f;

        wait_until(3);
        vectors++;
        if (cur !== ov(0, 1, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_state got=%b expected=%b", cur, ov(0, 1, 1, 0, 0, 0));
        end
        prev = cur;
        mon_en = 1'b1;

        // Normal bring-up: lock 5 cycles after RESETB release.
        n = cyc;
        reset = 1'b0;
        w = n + PRC;
        expect_at(w, ov(1, 1, 1, 0, 0, 0), "t1_pll_release");
        wait_until(w + 5);
        pll_locked = 1'b1;
        expect_at(w + 5 + SYNC_DET + LSC, ov(1, 0, 1, 0, 0, 0), "t1_sdram_release");
        expect_at(w + 5 + SYNC_DET + LSC + GAP, ov(1, 0, 0, 1, 0, 0), "t1_run");
        wait_until(w + 5 + SYNC_DET + LSC + GAP + 4);

        // Lock loss in RUN.
        r = cyc;
        pll_locked = 1'b0;
        expect_at(r + SYNC_DET, ov(0, 1, 1, 0, 0, 0), "t4_lockloss");
        expect_at(r + SYNC_DET + PRC, ov(1, 1, 1, 0, 0, 0), "t4_repulse_done");
        wait_until(r + SYNC_DET + PRC + 1);

        // One-cycle lock glitch at stable count 6.
        l = cyc;
        pll_locked = 1'b1;
        s = l + SYNC_DET;
        expect_at(s + 7 + LSC, ov(1, 0, 1, 0, 0, 0), "t3_sdram_release_late");
        expect_at(s + 7 + LSC + GAP, ov(1, 0, 0, 1, 0, 0), "t3_run");
        wait_until(s + 4);
        pll_locked = 1'b0;
        wait_until(s + 5);
        pll_locked = 1'b1;
        wait_until(s + 7 + LSC + GAP + 3);

        // soft_restart edge in RUN.
        q = cyc;
        soft_restart = 1'b1;
        expect_at(q + 1, ov(0, 1, 1, 0, 0, 0), "t5_soft_restart");
        expect_at(q + 1 + PRC, ov(1, 1, 1, 0, 0, 0), "t5_pll_release");
        expect_at(q + 1 + PRC + 1 + LSC, ov(1, 0, 1, 0, 0, 0), "t5_sdram_release");
        wait_until(q + 2);
        soft_restart = 1'b0;

        // reset pulse while in SDRAM_REL.
        wait_until(q + 1 + PRC + 1 + LSC);
        reset = 1'b1;
        expect_at(cyc + 1, ov(0, 1, 1, 0, 0, 0), "t6_reset_midseq");
        wait_until(cyc + 1);
        e = cyc;
        reset = 1'b0;
        expect_at(e + PRC, ov(1, 1, 1, 0, 0, 0), "t6_pll_release");
        expect_at(e + PRC + 1 + LSC, ov(1, 0, 1, 0, 0, 0), "t6_sdram_release");
        expect_at(e + PRC + 1 + LSC + GAP, ov(1, 0, 0, 1, 0, 0), "t6_run");
        wait_until(e + PRC + 1 + LSC + GAP + 3);

        // Lock never returns: retries, then FAULT.
        c = cyc;
        pll_locked = 1'b0;
        expect_at(c + SYNC_DET, ov(0, 1, 1, 0, 0, 0), "t2_lockloss");
        w = c + SYNC_DET + PRC;
        expect_at(w, ov(1, 1, 1, 0, 0, 0), "t2_try1");
        expect_at(w + LTO, ov(0, 1, 1, 0, 0, 1), "t2_timeout1");
        expect_at(w + LTO + PRC, ov(1, 1, 1, 0, 0, 1), "t2_try2");
        expect_at(w + 2 * LTO + PRC, ov(0, 1, 1, 0, 0, 2), "t2_timeout2");
        expect_at(w + 2 * LTO + 2 * PRC, ov(1, 1, 1, 0, 0, 2), "t2_try3");
        f = w + 3 * LTO + 2 * PRC;
        expect_at(f, ov(0, 1, 1, 0, 1, 3), "t2_fault");

        // soft_restart is ignored in FAULT; fault_clear leaves it.
        wait_until(f + 2);
        soft_restart = 1'b1;
        wait_until(f + 3);
        soft_restart = 1'b0;
        wait_until(f + 6);
        fault_clear = 1'b1;
        expect_at(f + 7, ov(0, 1, 1, 0, 0, 0), "t2_fault_clear");
        expect_at(f + 7 + PRC, ov(1, 1, 1, 0, 0, 0), "t2_pll_release");
        wait_until(f + 7);
        fault_clear = 1'b0;
        wait_until(f + 7 + PRC + 4);

        mon_en = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_expectations left=%0d required=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
